clock_counter: RTL and testbench

CLOCK_COUNTER -- requirements
Module: clock_counter

---
 rtl/clock_counter.sv | 44 ++++
 tb/tb_clock_counter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/clock_counter.sv
// 24-hour time-of-day counter advanced by a 1 Hz clock.
// Seconds, minutes and hours ripple their carries within a single edge.
module clock_counter (
  input  logic       clk_1Hz,
  input  logic       reset,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours
);

  logic [5:0] r_seconds;
  logic [5:0] r_minutes;
  logic [4:0] r_hours;

  logic w_secWrap;
  logic w_minWrap;
  logic w_hourWrap;

  // Wrap tests use >= so an unreset power-up value still lands back in range.
  assign w_secWrap  = (r_seconds >= 6'd59);
  assign w_minWrap  = (r_minutes >= 6'd59);
  assign w_hourWrap = (r_hours   >= 5'd23);

  always_ff @(posedge clk_1Hz) begin
    if (reset) begin
      r_seconds <= 6'd0;
      r_minutes <= 6'd0;
      r_hours   <= 5'd0;
    end else begin
      r_seconds <= w_secWrap ? 6'd0 : r_seconds + 6'd1;
      if (w_secWrap) begin
        r_minutes <= w_minWrap ? 6'd0 : r_minutes + 6'd1;
        if (w_minWrap) begin
          r_hours <= w_hourWrap ? 5'd0 : r_hours + 5'd1;
        end
      end
    end
  end

  assign seconds = r_seconds;
  assign minutes = r_minutes;
  assign hours   = r_hours;

endmodule

// File: tb/tb_clock_counter.sv
// Scoreboard bench for clock_counter: the model keeps time as a plain count of
// seconds since midnight and derives hh:mm:ss from it with division.
module tb_clock_counter;

  logic       clk_1Hz;
  logic       reset;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;

  int tests    = 0;
  int failures = 0;
  int modelT   = 0;
  int expQ[$];

  clock_counter dut (
    .clk_1Hz (clk_1Hz),
    .reset   (reset),
    .seconds (seconds),
    .minutes (minutes),
    .hours   (hours)
  );

  initial clk_1Hz = 1'b0;
  always #5 clk_1Hz = ~clk_1Hz;

  task automatic checkOutput(input string name, input int h, input int m, input int s);
    tests++;
    if (int'(hours) != h || int'(minutes) != m || int'(seconds) != s) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d:%0d:%0d expected %0d:%0d:%0d",
               name, $time, hours, minutes, seconds, h, m, s);
    end
  endtask

  task automatic checkRange();
    tests++;
    if (seconds > 6'd59 || minutes > 6'd59 || hours > 5'd23) begin
      failures++;
      $display("[TB] FAIL range at %0t: got %0d:%0d:%0d expected fields within 23:59:59",
               $time, hours, minutes, seconds);
    end
  endtask

  // Drive reset for the coming rising edge and queue the time it must produce.
  task automatic applyStimulus(input logic rst);
    @(negedge clk_1Hz);
    reset  = rst;
    modelT = rst ? 0 : (modelT + 1) % 86400;
    expQ.push_back(modelT);
  endtask

  task automatic checkAfterEdge(input string name, input int h, input int m, input int s);
    @(posedge clk_1Hz);
    #2;
    checkOutput(name, h, m, s);
  endtask

  // Run n enabled edges from a freshly reset counter, with fixed-value checks at the carry boundaries.
  task automatic runFromReset(input int n);
    for (int i = 1; i <= n; i++) begin
      applyStimulus(1'b0);
      case (i)
        59:    checkAfterEdge("edge59",    0,  0, 59);
        60:    checkAfterEdge("edge60",    0,  1,  0);
        3599:  checkAfterEdge("edge3599",  0, 59, 59);
        3600:  checkAfterEdge("edge3600",  1,  0,  0);
        86399: checkAfterEdge("edge86399", 23, 59, 59);
        86400: checkAfterEdge("edge86400", 0,  0,  0);
        86401: checkAfterEdge("edge86401", 0,  0,  1);
        default: ;
      endcase
    end
  endtask

  // Monitor: every rising edge presents a new time, compared against the queued expectation.
  initial begin
    forever begin
      @(posedge clk_1Hz);
      #1;
      if (expQ.size() > 0) begin
        int t;
        t = expQ.pop_front();
        checkOutput("scoreboard", t / 3600, (t / 60) % 60, t % 60);
        checkRange();
      end
    end
  end

  initial begin
    int waitCycles;
    reset = 1'b1;

    // Three reset edges then 100 counting edges reaches 00:01:40.
    repeat (3) applyStimulus(1'b1);
    for (int i = 0; i < 99; i++) applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkAfterEdge("after100", 0, 1, 40);

    // Reset raised between edges must not disturb the outputs until the next edge.
    applyStimulus(1'b1);
    #1;
    checkOutput("resetHold", 0, 1, 40);
    checkAfterEdge("resetClear", 0, 0, 0);
    applyStimulus(1'b1);
    checkAfterEdge("resetStay", 0, 0, 0);
    applyStimulus(1'b1);

    // Full day from reset, including the hour carry and midnight wrap.
    runFromReset(86401);

    // Random reset pulses, some landing on carry edges.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end
    applyStimulus(1'b1);
    for (int i = 0; i < 59; i++) applyStimulus(1'b0);
    applyStimulus(($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk_1Hz);
      waitCycles++;
    end
    #3;
    if (expQ.size() > 0) begin
      tests++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
